// File: rtl/t09_lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// t09_lcd_bus_receiver
//
// Receives the write side of an 8080-style LCD controller bus (the kind of
// bus used by ILI9341-class panels). It decodes command bytes and the
// parameter bytes that follow them. It keeps the column/page address window
// (CASET / PASET) and converts RAMWR (0x2C) data streams into RGB565 pixels
// tagged with their screen coordinates.
//
// The bus is asynchronous to clk. wr, dcx and D are brought into the clk
// domain with two-flop synchronisers. A third wr flop gives the rising-edge
// detector. All outputs are registered, so a pulse shows up on the third
// rising clk edge after wr rises.
//
// Parameters
//   COLS        display width  (reset column window 0..COLS-1)
//   ROWS        display height (reset page window   0..ROWS-1)
//
// Ports
//   clk         system clock, all state on its rising edge
//   nrst        asynchronous active-low reset
//   wr          8080 write strobe, byte taken on its rising edge
//   dcx         0 = command byte, 1 = data/parameter byte
//   D           bus byte
//   cmd_valid   one-cycle pulse per received command byte
//   cmd_code    last command byte, held until the next command
//   pixel_valid one-cycle pulse per completed RGB565 pixel
//   pixel_x     column of the emitted pixel, held between pulses
//   pixel_y     page (row) of the emitted pixel, held between pulses
//   pixel_data  emitted pixel, {first byte, second byte}
//   frame_done  pulse coincident with the last pixel of the window
//   win_err     pulse when a CASET/PASET completes with start > end
// ---------------------------------------------------------------------------
module t09_lcd_bus_receiver #(
  parameter int COLS = 320,
  parameter int ROWS = 240
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        wr,
  input  logic        dcx,
  input  logic [7:0]  D,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pixel_valid,
  output logic [8:0]  pixel_x,
  output logic [8:0]  pixel_y,
  output logic [15:0] pixel_data,
  output logic        frame_done,
  output logic        win_err
);

  // Reset window limits, narrowed to the 9-bit coordinate width.
  localparam logic [8:0] EC_RESET = 9'(COLS - 1);
  localparam logic [8:0] EP_RESET = 9'(ROWS - 1);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET_P,
    PASET_P,
    RAM_HI,
    RAM_LO,
    IGNORE
  } state_t;

  // -------------------------------------------------------------------------
  // Bus synchronisers
  // -------------------------------------------------------------------------
  logic [2:0] wr_sync;
  logic       dcx_s1, dcx_s2;
  logic [7:0] d_s1, d_s2;
  logic       byte_stb;

  // wr_sync[0] is stage 1, wr_sync[1] is stage 2 and wr_sync[2] is the
  // extra stage used only for edge detection. dcx and D only need the two
  // stages. The write phases are held for at least two clocks, so both
  // have settled by the time stage 2 of wr sees the rising edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_sync <= '0;
      dcx_s1  <= 1'b0;
      dcx_s2  <= 1'b0;
      d_s1    <= '0;
      d_s2    <= '0;
    end else begin
      wr_sync <= {wr_sync[1:0], wr};
      dcx_s1  <= dcx;
      dcx_s2  <= dcx_s1;
      d_s1    <= D;
      d_s2    <= d_s1;
    end
  end

  assign byte_stb = wr_sync[1] & ~wr_sync[2];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [1:0] param_cnt, param_cnt_nxt;
  logic [8:0] par_start, par_start_nxt;
  logic       par_end_msb, par_end_msb_nxt;

  // Committed address window, changed only by CASET/PASET/SWRESET.
  logic [8:0] sc, sc_nxt, ec, ec_nxt, sp, sp_nxt, ep, ep_nxt;

  // Window captured at RAMWR. A window change during a RAMWR stream only
  // takes effect at the next RAMWR.
  logic [8:0] act_sc, act_sc_nxt, act_ec, act_ec_nxt;
  logic [8:0] act_sp, act_sp_nxt, act_ep, act_ep_nxt;

  logic [8:0] cur_x, cur_x_nxt, cur_y, cur_y_nxt;
  logic [7:0] hi_byte, hi_byte_nxt;

  logic        cmd_valid_nxt, pixel_valid_nxt, frame_done_nxt, win_err_nxt;
  logic [7:0]  cmd_code_nxt;
  logic [8:0]  pixel_x_nxt, pixel_y_nxt;
  logic [15:0] pixel_data_nxt;

  logic [8:0]  new_end;

  // All registered state. Reset aborts any transaction in flight. The first
  // byte after release is therefore decoded from IDLE with the default window.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      param_cnt   <= '0;
      par_start   <= '0;
      par_end_msb <= 1'b0;
      sc          <= '0;
      ec          <= EC_RESET;
      sp          <= '0;
      ep          <= EP_RESET;
      act_sc      <= '0;
      act_ec      <= EC_RESET;
      act_sp      <= '0;
      act_ep      <= EP_RESET;
      cur_x       <= '0;
      cur_y       <= '0;
      hi_byte     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_data  <= '0;
      frame_done  <= 1'b0;
      win_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      param_cnt   <= param_cnt_nxt;
      par_start   <= par_start_nxt;
      par_end_msb <= par_end_msb_nxt;
      sc          <= sc_nxt;
      ec          <= ec_nxt;
      sp          <= sp_nxt;
      ep          <= ep_nxt;
      act_sc      <= act_sc_nxt;
      act_ec      <= act_ec_nxt;
      act_sp      <= act_sp_nxt;
      act_ep      <= act_ep_nxt;
      cur_x       <= cur_x_nxt;
      cur_y       <= cur_y_nxt;
      hi_byte     <= hi_byte_nxt;
      cmd_valid   <= cmd_valid_nxt;
      cmd_code    <= cmd_code_nxt;
      pixel_valid <= pixel_valid_nxt;
      pixel_x     <= pixel_x_nxt;
      pixel_y     <= pixel_y_nxt;
      pixel_data  <= pixel_data_nxt;
      frame_done  <= frame_done_nxt;
      win_err     <= win_err_nxt;
    end
  end

  // Next-state and output decode. Everything holds by default and the pulse
  // outputs default low. A command byte always wins over the current state,
  // and clearing param_cnt / re-entering RAM_HI drops any half-collected
  // parameter set or half pixel.
  always_comb begin
    state_nxt       = state;
    param_cnt_nxt   = param_cnt;
    par_start_nxt   = par_start;
    par_end_msb_nxt = par_end_msb;
    sc_nxt          = sc;
    ec_nxt          = ec;
    sp_nxt          = sp;
    ep_nxt          = ep;
    act_sc_nxt      = act_sc;
    act_ec_nxt      = act_ec;
    act_sp_nxt      = act_sp;
    act_ep_nxt      = act_ep;
    cur_x_nxt       = cur_x;
    cur_y_nxt       = cur_y;
    hi_byte_nxt     = hi_byte;
    cmd_valid_nxt   = 1'b0;
    cmd_code_nxt    = cmd_code;
    pixel_valid_nxt = 1'b0;
    pixel_x_nxt     = pixel_x;
    pixel_y_nxt     = pixel_y;
    pixel_data_nxt  = pixel_data;
    frame_done_nxt  = 1'b0;
    win_err_nxt     = 1'b0;
    new_end         = {par_end_msb, d_s2};

    if (byte_stb) begin
      if (!dcx_s2) begin
        cmd_valid_nxt = 1'b1;
        cmd_code_nxt  = d_s2;
        param_cnt_nxt = '0;
        case (d_s2)
          CMD_CASET: state_nxt = CASET_P;
          CMD_PASET: state_nxt = PASET_P;
          CMD_RAMWR: begin
            state_nxt  = RAM_HI;
            cur_x_nxt  = sc;
            cur_y_nxt  = sp;
            act_sc_nxt = sc;
            act_ec_nxt = ec;
            act_sp_nxt = sp;
            act_ep_nxt = ep;
          end
          CMD_SWRESET: begin
            state_nxt = IDLE;
            sc_nxt    = '0;
            ec_nxt    = EC_RESET;
            sp_nxt    = '0;
            ep_nxt    = EP_RESET;
          end
          default: state_nxt = IGNORE;
        endcase
      end else begin
        case (state)
          // Parameter order is start MSB, start LSB, end MSB, end LSB.
          // Only bit 0 of each MSB byte matters for 9-bit coordinates.
          CASET_P, PASET_P: begin
            param_cnt_nxt = param_cnt + 2'd1;
            case (param_cnt)
              2'd0: par_start_nxt[8]   = d_s2[0];
              2'd1: par_start_nxt[7:0] = d_s2;
              2'd2: par_end_msb_nxt    = d_s2[0];
              default: begin
                state_nxt = IDLE;
                if (par_start <= new_end) begin
                  if (state == CASET_P) begin
                    sc_nxt = par_start;
                    ec_nxt = new_end;
                  end else begin
                    sp_nxt = par_start;
                    ep_nxt = new_end;
                  end
                end else begin
                  win_err_nxt = 1'b1;
                end
              end
            endcase
          end
          RAM_HI: begin
            hi_byte_nxt = d_s2;
            state_nxt   = RAM_LO;
          end
          // Emit at the current cursor, then advance in raster order inside
          // the captured window. The last pixel of the window flags
          // frame_done and wraps the cursor back to the window origin.
          RAM_LO: begin
            pixel_valid_nxt = 1'b1;
            pixel_x_nxt     = cur_x;
            pixel_y_nxt     = cur_y;
            pixel_data_nxt  = {hi_byte, d_s2};
            state_nxt       = RAM_HI;
            if (cur_x != act_ec) begin
              cur_x_nxt = cur_x + 9'd1;
            end else if (cur_y != act_ep) begin
              cur_x_nxt = act_sc;
              cur_y_nxt = cur_y + 9'd1;
            end else begin
              cur_x_nxt      = act_sc;
              cur_y_nxt      = act_sp;
              frame_done_nxt = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_t09_lcd_bus_receiver.sv
// ---------------------------------------------------------------------------
// tb_t09_lcd_bus_receiver
//
// Drives 8080 write cycles into t09_lcd_bus_receiver. When a byte is
// written, the expected command codes, pixels and window errors are pushed
// into queues. A negedge monitor pops those queues and compares them
// whenever the DUT raises a pulse. Every byte write also checks that its
// pulse appears on exactly the third clk edge after wr rises.
// ---------------------------------------------------------------------------
module tb_t09_lcd_bus_receiver;

  typedef struct packed {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] data;
    logic        fd;
  } pix_t;

  logic        clk;
  logic        nrst;
  logic        wr;
  logic        dcx;
  logic [7:0]  D;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic        pixel_valid;
  logic [8:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [15:0] pixel_data;
  logic        frame_done;
  logic        win_err;

  int          n_compared;
  int          n_mismatched;
  logic [7:0]  exp_cmd[$];
  pix_t        exp_pix[$];
  int          exp_err;

  t09_lcd_bus_receiver dut (
    .clk         (clk),
    .nrst        (nrst),
    .wr          (wr),
    .dcx         (dcx),
    .D           (D),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_data  (pixel_data),
    .frame_done  (frame_done),
    .win_err     (win_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
    end
  endtask

  // One bus write. The low phase lasts at least two clocks and the high
  // phase four. The pulse outputs must be low after edges 1-2, show the
  // expected pulse after edge 3 and be low again after edge 4.
  task automatic applyStimulus(input logic dc, input logic [7:0] b,
                               input logic pulse);
    dcx = dc;
    D   = b;
    repeat (2) @(negedge clk);
    wr = 1'b1;
    repeat (2) @(posedge clk);
    #1 checkOutput("pulse_early", {31'd0, cmd_valid | pixel_valid | win_err}, 32'd0);
    @(posedge clk);
    #1 checkOutput("pulse_latency", {31'd0, cmd_valid | pixel_valid | win_err}, {31'd0, pulse});
    @(posedge clk);
    #1 checkOutput("pulse_width", {31'd0, cmd_valid | pixel_valid | win_err}, 32'd0);
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic sendCmd(input logic [7:0] code);
    exp_cmd.push_back(code);
    applyStimulus(1'b0, code, 1'b1);
  endtask

  task automatic sendData(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0);
  endtask

  task automatic sendErrParam(input logic [7:0] b);
    exp_err++;
    applyStimulus(1'b1, b, 1'b1);
  endtask

  task automatic sendPixel(input logic [8:0] x, input logic [8:0] y,
                           input logic [15:0] data, input logic fd);
    exp_pix.push_back('{x: x, y: y, data: data, fd: fd});
    applyStimulus(1'b1, data[15:8], 1'b0);
    applyStimulus(1'b1, data[7:0], 1'b1);
  endtask

  task automatic sendParams(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    sendData(b0);
    sendData(b1);
    sendData(b2);
    sendData(b3);
  endtask

  // Scoreboard side: every pulse must match the head of its queue.
  always @(negedge clk) begin
    if (nrst) begin
      if (cmd_valid) begin
        checkOutput("cmd_expected", {31'd0, exp_cmd.size() > 0}, 32'd1);
        if (exp_cmd.size() > 0) checkOutput("cmd_code", {24'd0, cmd_code}, {24'd0, exp_cmd.pop_front()});
      end
      if (pixel_valid) begin
        checkOutput("pix_expected", {31'd0, exp_pix.size() > 0}, 32'd1);
        if (exp_pix.size() > 0) begin
          pix_t e;
          e = exp_pix.pop_front();
          checkOutput("pixel_x", {23'd0, pixel_x}, {23'd0, e.x});
          checkOutput("pixel_y", {23'd0, pixel_y}, {23'd0, e.y});
          checkOutput("pixel_data", {16'd0, pixel_data}, {16'd0, e.data});
          checkOutput("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        end
      end else if (frame_done) begin
        checkOutput("fd_without_pixel", {31'd0, pixel_valid}, 32'd1);
      end
      if (win_err) begin
        checkOutput("err_expected", {31'd0, exp_err > 0}, 32'd1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    exp_err      = 0;
    nrst = 1'b0;
    wr   = 1'b0;
    dcx  = 1'b0;
    D    = 8'h00;
    repeat (4) @(negedge clk);
    checkOutput("rst_cmd_code", {24'd0, cmd_code}, 32'h00);
    checkOutput("rst_pixel_x", {23'd0, pixel_x}, 32'd0);
    checkOutput("rst_pixel_y", {23'd0, pixel_y}, 32'd0);
    checkOutput("rst_pixel_data", {16'd0, pixel_data}, 32'd0);
    checkOutput("rst_pulses", {28'd0, cmd_valid, pixel_valid, frame_done, win_err}, 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // First pixel after reset lands at the origin.
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'hF800, 1'b0);
    checkOutput("cmd_code_held", {24'd0, cmd_code}, 32'h2C);

    // 3x2 window with wrap and frame_done on its last pixel.
    sendCmd(8'h2A);
    sendParams(8'h00, 8'h05, 8'h00, 8'h07);
    sendCmd(8'h2B);
    sendParams(8'h00, 8'h02, 8'h00, 8'h03);
    sendCmd(8'h2C);
    sendPixel(9'd5, 9'd2, 16'h01C0, 1'b0);
    sendPixel(9'd6, 9'd2, 16'h11C1, 1'b0);
    sendPixel(9'd7, 9'd2, 16'h21C2, 1'b0);
    sendPixel(9'd5, 9'd3, 16'h31C3, 1'b0);
    sendPixel(9'd6, 9'd3, 16'h41C4, 1'b0);
    sendPixel(9'd7, 9'd3, 16'h51C5, 1'b1);
    sendPixel(9'd5, 9'd2, 16'h61C6, 1'b0);
    sendPixel(9'd6, 9'd2, 16'h71C7, 1'b0);

    // Unknown command: its parameter is swallowed and the window is kept.
    sendCmd(8'h36);
    sendData(8'h48);
    sendCmd(8'h2C);
    sendPixel(9'd5, 9'd2, 16'h1122, 1'b0);

    // Software reset restores the default window. Data in IDLE is ignored.
    sendCmd(8'h01);
    sendData(8'h55);
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'h0102, 1'b0);
    sendPixel(9'd1, 9'd0, 16'h0304, 1'b0);

    // Inverted CASET and PASET raise win_err and leave the window alone.
    sendCmd(8'h2A);
    sendData(8'h00);
    sendData(8'h0A);
    sendData(8'h00);
    sendErrParam(8'h04);
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'h3344, 1'b0);
    sendCmd(8'h2B);
    sendData(8'h01);
    sendData(8'h00);
    sendData(8'h00);
    sendErrParam(8'h05);

    // Half pixel discarded by a new RAMWR.
    sendCmd(8'h2C);
    sendData(8'h12);
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'hABCD, 1'b0);

    // 9-bit coordinates: only bit 0 of each MSB parameter is kept.
    sendCmd(8'h2A);
    sendParams(8'h03, 8'h01, 8'hFF, 8'h3F);
    sendCmd(8'h2B);
    sendParams(8'h00, 8'hEF, 8'h00, 8'hEF);
    sendCmd(8'h2C);
    sendPixel(9'd257, 9'd239, 16'hA001, 1'b0);
    sendPixel(9'd258, 9'd239, 16'hA002, 1'b0);

    // Single-pixel window (start == end is accepted): every pixel ends a frame.
    sendCmd(8'h2A);
    sendParams(8'h00, 8'h00, 8'h00, 8'h00);
    sendCmd(8'h2B);
    sendParams(8'h00, 8'h00, 8'h00, 8'h00);
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'h0F0F, 1'b1);
    sendPixel(9'd0, 9'd0, 16'hF0F0, 1'b1);

    // Reset in the middle of a CASET: everything is aborted.
    sendCmd(8'h2A);
    sendData(8'h00);
    sendData(8'h01);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_cmd_code", {24'd0, cmd_code}, 32'h00);
    checkOutput("abort_pixel_x", {23'd0, pixel_x}, 32'd0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    sendCmd(8'h2C);
    sendPixel(9'd0, 9'd0, 16'h0001, 1'b0);
    sendPixel(9'd1, 9'd0, 16'h0002, 1'b0);

    repeat (8) @(negedge clk);
    checkOutput("cmd_queue_drained", exp_cmd.size(), 32'd0);
    checkOutput("pix_queue_drained", exp_pix.size(), 32'd0);
    checkOutput("err_drained", exp_err, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/t09_lcd_bus_receiver.md
T09_LCD_BUS_RECEIVER -- requirements
Module: t09_lcd_bus_receiver

Interface
REQ-001 SHALL have parameter COLS, default 320, meaning display width; reset column window is 0..COLS-1.
REQ-002 SHALL have parameter ROWS, default 240, meaning display height; reset page window is 0..ROWS-1.
REQ-003 SHALL have port clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr  input  1  8080 write strobe; byte is taken on its rising edge.
REQ-006 SHALL have port dcx  input  1  0 = command byte, 1 = data/parameter byte.
REQ-007 SHALL have port D  input  8  bus byte.
REQ-008 SHALL have port cmd_valid  output  1  one-cycle pulse per command byte received.
REQ-009 SHALL have port cmd_code  output  8  last command byte, held until next command.
REQ-010 SHALL have port pixel_valid  output  1  one-cycle pulse per completed RGB565 pixel.
REQ-011 SHALL have port pixel_x  output  9  column of emitted pixel, held between pulses.
REQ-012 SHALL have port pixel_y  output  9  page (row) of emitted pixel, held between pulses.
REQ-013 SHALL have port pixel_data  output  16  emitted pixel, {first byte, second byte}.
REQ-014 SHALL have port frame_done  output  1  pulse coincident with the last pixel of the window.
REQ-015 SHALL have port win_err  output  1  pulse when a CASET/PASET completes with start > end.

Function
REQ-016 SHALL pass wr, dcx, D through two-flop synchronisers; byte strobe = stage2 wr high and stage3 wr low; dcx/D taken from stage2.
REQ-017 SHALL register all outputs; pulse outputs assert on the 3rd rising clk edge after wr rises, high for exactly one cycle.
REQ-018 SHALL implement states IDLE, CASET_P, PASET_P, RAM_HI, RAM_LO, IGNORE.
REQ-019 SHALL, on any command byte in any state, pulse cmd_valid, update cmd_code, discard any partial parameter set or half pixel, then branch: 0x2A -> CASET_P, 0x2B -> PASET_P, 0x2C -> RAM_HI with cursor = (SC, SP), 0x01 -> restore reset window and go IDLE, other -> IGNORE.
REQ-020 SHALL in CASET_P/PASET_P collect 4 parameter bytes (start MSB, start LSB, end MSB, end LSB); only bit 0 of each MSB byte is kept (9-bit values).
REQ-021 SHALL commit the new start/end only after the 4th byte and only if start <= end; otherwise pulse win_err and keep the old window; either way go IDLE.
REQ-022 SHALL in RAM_HI store the data byte and go RAM_LO; in RAM_LO emit pixel_valid with current cursor and {hi, lo}, advance cursor, go RAM_HI.
REQ-023 SHALL advance cursor: x < EC -> x+1; x == EC -> x = SC and y+1; x == EC and y == EP -> wrap to (SC, SP) and pulse frame_done with that pixel.
REQ-024 SHALL ignore data bytes in IDLE and IGNORE.
REQ-025 SHALL treat a window change mid-RAMWR as effective only at the next 0x2C.
REQ-026 SHALL accept back-to-back bytes with wr high/low phases each >= 2 clk cycles; shorter phases are unsupported.

Reset
REQ-027 SHALL, while nrst low, clear synchronisers, set state IDLE, all pulses 0, cmd_code 0x00, pixel_x/pixel_y/pixel_data 0, SC=0, EC=COLS-1, SP=0, EP=ROWS-1.
REQ-028 SHALL treat nrst asserted mid-transaction as full abort; the first byte after release is decoded from IDLE.

Verification
REQ-029 SHALL pass: cmd 0x2A, data 00 05 00 07; cmd 0x2B, data 00 02 00 03; cmd 0x2C; 16 data bytes -> 8 pixels at (5,2),(6,2),(7,2),(5,3),(6,3),(7,3),(5,2),(6,2); frame_done only on (7,3).
REQ-030 SHALL pass: after reset, cmd 0x2C, data F8 00 -> pixel_valid at (0,0), pixel_data 0xF800, cmd_code 0x2C.
REQ-031 SHALL pass: cmd 0x2A, data 00 0A 00 04 -> win_err pulse; subsequent 0x2C write lands at x=0.
REQ-032 SHALL pass: cmd 0x2C, one data byte 0x12, cmd 0x2C, data AB CD -> single pixel 0xABCD at (SC,SP); no pixel for 0x12.
REQ-033 SHALL pass: cmd 0x2A, data 00 01 then nrst pulse, then cmd 0x2C, data 00 01 -> pixel at (0,0); window equals reset default.
REQ-034 SHALL pass: cmd 0x36, data 48 -> cmd_valid once, cmd_code 0x36, no pixel_valid, window unchanged.
